// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared width helpers for the NoC link buffers
package noc_pkg;

    // Width of a VC id field; a single VC still needs one bit.
    function automatic int vc_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Width of a FIFO slot index.
    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// rtl/vc_fifo.sv - per-VC circular FIFO with registered almost-full and overflow pulse
module vc_fifo
    import noc_pkg::*;
#(
    parameter int D_W   = 32,
    parameter int DEPTH = 4,
    parameter int SKID  = 1,
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [D_W-1:0]   din,
    output logic [D_W-1:0]   head,
    output logic [CNT_W-1:0] cnt,
    output logic             afull,
    output logic             ovf
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] THR  = CNT_W'(DEPTH - SKID);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [D_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic             accept;
    logic [CNT_W-1:0] cnt_next;

    // DEPTH need not be a power of two, so wrap by compare rather than overflow.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    always_comb begin
        accept   = push && ((cnt != FULL) || pop);
        ovf      = push && !accept;
        cnt_next = cnt + CNT_W'(accept) - CNT_W'(pop);
        head     = mem[rptr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            rptr  <= '0;
            wptr  <= '0;
            afull <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            afull <= (cnt_next >= THR);
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            if (accept) begin
                wptr <= ptr_inc(wptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wptr] <= din;
        end
    end

endmodule

// File: rtl/vc_skid_fifo.sv
// rtl/vc_skid_fifo.sv - multi-VC skid buffer with round-robin output arbitration
module vc_skid_fifo
    import noc_pkg::*;
#(
    parameter int D_W   = 32,
    parameter int N_VC  = 2,
    parameter int DEPTH = 4,
    parameter int SKID  = 1,
    localparam int VC_W = vc_w(N_VC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_v,
    input  logic [VC_W-1:0] i_vc,
    input  logic [D_W-1:0]  i_d,
    output logic [N_VC-1:0] i_b,
    input  logic [N_VC-1:0] o_b,
    output logic            o_v,
    output logic [VC_W-1:0] o_vc,
    output logic [D_W-1:0]  o_d,
    output logic            err
);

    localparam int CNT_W = cnt_w(DEPTH);

    logic [N_VC-1:0]  push;
    logic [N_VC-1:0]  pop;
    logic [N_VC-1:0]  ovf;
    logic [N_VC-1:0]  eligible;
    logic [D_W-1:0]   head [N_VC];
    logic [CNT_W-1:0] cnt  [N_VC];
    logic [VC_W-1:0]  rr_ptr;
    logic [VC_W-1:0]  grant;
    logic             found;
    logic             bad_vc;

    assign bad_vc = i_v && ({1'b0, i_vc} >= (VC_W + 1)'(N_VC));

    for (genvar v = 0; v < N_VC; v++) begin : g_vc
        assign push[v]     = i_v && (i_vc == VC_W'(v));
        assign eligible[v] = (cnt[v] != '0) && !o_b[v];
        assign pop[v]      = found && (grant == VC_W'(v));

        vc_fifo #(
            .D_W   (D_W),
            .DEPTH (DEPTH),
            .SKID  (SKID)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[v]),
            .pop   (pop[v]),
            .din   (i_d),
            .head  (head[v]),
            .cnt   (cnt[v]),
            .afull (i_b[v]),
            .ovf   (ovf[v])
        );
    end

    // Scan starts just past the last winner so every VC gets a turn.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 1; i <= N_VC; i++) begin
            int idx;
            idx = (int'(rr_ptr) + i) % N_VC;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                grant = VC_W'(idx);
            end
        end
    end

    assign o_v  = found;
    assign o_vc = grant;
    assign o_d  = head[grant];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= VC_W'(N_VC - 1);
            err    <= 1'b0;
        end else begin
            if (found) begin
                rr_ptr <= grant;
            end
            if ((|ovf) || bad_vc) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vc_skid_fifo.sv
// tb/tb_vc_skid_fifo.sv - self-checking bench for vc_skid_fifo against a queue model
module tb_vc_skid_fifo;

    localparam int D_W   = 32;
    localparam int N_VC  = 2;
    localparam int DEPTH = 4;
    localparam int SKID  = 1;
    localparam int VC_W  = 1;

    logic            clk  = 1'b0;
    logic            rst  = 1'b0;
    logic            i_v  = 1'b0;
    logic [VC_W-1:0] i_vc = '0;
    logic [D_W-1:0]  i_d  = '0;
    logic [N_VC-1:0] i_b;
    logic [N_VC-1:0] o_b  = '0;
    logic            o_v;
    logic [VC_W-1:0] o_vc;
    logic [D_W-1:0]  o_d;
    logic            err;

    int checks   = 0;
    int failures = 0;

    logic [D_W-1:0] q [N_VC][$];
    int             rr;
    bit             m_err;

    vc_skid_fifo #(
        .D_W   (D_W),
        .N_VC  (N_VC),
        .DEPTH (DEPTH),
        .SKID  (SKID)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .i_v  (i_v),
        .i_vc (i_vc),
        .i_d  (i_d),
        .i_b  (i_b),
        .o_b  (o_b),
        .o_v  (o_v),
        .o_vc (o_vc),
        .o_d  (o_d),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        i_v = 1'b0;
        #1;
        for (int k = 0; k < N_VC; k++) q[k].delete();
        rr    = N_VC - 1;
        m_err = 1'b0;
        chk("rst_o_v", 64'(o_v), 64'd0);
        chk("rst_i_b", 64'(i_b), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One cycle: drive, check against the model, then advance the model at the edge.
    task automatic step(input bit v, input int vc, input logic [D_W-1:0] d,
                        input logic [N_VC-1:0] ob);
        bit              exp_v;
        int              g;
        logic [N_VC-1:0] exp_ib;
        i_v  = v;
        i_vc = VC_W'(vc);
        i_d  = d;
        o_b  = ob;
        #1;
        exp_v = 1'b0;
        g     = 0;
        for (int i = 1; i <= N_VC; i++) begin
            int k;
            k = (rr + i) % N_VC;
            if (!exp_v && q[k].size() > 0 && !ob[k]) begin
                exp_v = 1'b1;
                g     = k;
            end
        end
        for (int k = 0; k < N_VC; k++) exp_ib[k] = (q[k].size() >= DEPTH - SKID);
        chk("o_v", 64'(o_v), 64'(exp_v));
        chk("o_vc", 64'(o_vc), exp_v ? 64'(g) : 64'd0);
        if (exp_v) chk("o_d", 64'(o_d), 64'(q[g][0]));
        chk("i_b", 64'(i_b), 64'(exp_ib));
        chk("err", 64'(err), 64'(m_err));
        @(posedge clk);
        if (exp_v) begin
            void'(q[g].pop_front());
            rr = g;
        end
        if (v) begin
            if (vc < N_VC && q[vc].size() < DEPTH) q[vc].push_back(d);
            else m_err = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        do_reset();
        step(0, 0, '0, 2'b00);

        for (int i = 0; i < 4; i++) step(1, 0, 32'hA0 + 32'(i), 2'b01);
        for (int i = 0; i < 6; i++) step(0, 0, '0, 2'b00);

        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 32'hB0 + 32'(i), 2'b11);
        for (int i = 0; i < 3; i++) step(1, 1, 32'hC0 + 32'(i), 2'b11);
        for (int i = 0; i < 7; i++) step(0, 0, '0, 2'b00);

        for (int i = 0; i < 2; i++) step(1, 0, 32'hD0 + 32'(i), 2'b10);
        step(1, 1, 32'hE0, 2'b10);
        step(0, 0, '0, 2'b10);
        step(0, 0, '0, 2'b00);
        step(0, 0, '0, 2'b00);

        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 32'hF0 + 32'(i), 2'b01);
        step(0, 0, '0, 2'b01);
        step(0, 0, '0, 2'b01);
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 32'hF0 + 32'(i), 2'b01);
        step(1, 0, 32'hF9, 2'b00);
        for (int i = 0; i < 6; i++) step(0, 0, '0, 2'b00);

        step(1, 1, 32'h77, 2'b00);
        step(0, 0, '0, 2'b00);
        step(0, 0, '0, 2'b00);

        for (int i = 0; i < 4; i++) step(1, i % 2, 32'h50 + 32'(i), 2'b11);
        step(0, 0, '0, 2'b00);
        do_reset();
        step(0, 0, '0, 2'b00);

        for (int n = 0; n < 400; n++) begin
            bit              v;
            logic [N_VC-1:0] ob;
            v  = ($urandom_range(0, 9) < 6);
            ob = ($urandom_range(0, 3) == 0) ? N_VC'($urandom_range(0, 3)) : '0;
            step(v, int'($urandom_range(0, N_VC - 1)), D_W'($urandom), ob);
        end
        for (int i = 0; i < 10; i++) step(0, 0, '0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vc_skid_fifo.md
Name: vc_skid_fifo

Overview:
Multi-virtual-channel successor to the single-entry shadow register on torus router links. It buffers up to DEPTH flits per VC and drives per-VC backpressure upstream with configurable skid slack. A round-robin arbiter selects among VCs whose downstream is not backpressured, and the winner drives one shared output link. It sits between a link input and the router crossbar, so that dateline VCs no longer block each other.

Parameters:
D_W, 32, flit data width
N_VC, 2, number of virtual channels (>=1)
DEPTH, 4, entries per VC FIFO (>=SKID+1; any integer, not restricted to powers of two)
SKID, 1, number of words upstream may still send after i_b[v] rises

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset (block in reset while rst==0)
i_v  input  1  input flit valid
i_vc  input  VC_W  VC id of input flit; VC_W = max(1, clog2(N_VC))
i_d  input  D_W  input flit data
i_b  output  N_VC  per-VC backpressure to upstream, flop-driven
o_b  input  N_VC  per-VC backpressure from downstream
o_v  output  1  output flit valid; a transfer occurs every cycle o_v==1
o_vc  output  VC_W  VC id of output flit
o_d  output  D_W  output flit data
err  output  1  sticky overflow flag

Behaviour:
- Reset (rst==0, asynchronous): all FIFO counts, read and write pointers = 0; i_b = 0; err = 0; RR pointer = N_VC-1, so VC0 has first priority. o_v = 0 follows combinationally from empty FIFOs. Data storage is not reset.
- Push:
  - When i_v==1, the flit is written to FIFO[i_vc] at the clock edge.
  - i_b is advisory only. The push is accepted if cnt[i_vc] < DEPTH, or if FIFO[i_vc] pops in the same cycle.
  - Otherwise the flit is dropped and err sets (sticky until reset).
  - i_vc >= N_VC with i_v==1: flit dropped, err sets.
- Backpressure: i_b[v] is a register. At each edge it loads (cnt_next[v] >= DEPTH-SKID), so it is high in the cycle after occupancy reaches the threshold. Upstream that honours i_b within SKID cycles never overflows.
- Pop / arbitration (combinational within the cycle):
  - eligible[v] = (cnt[v] != 0) && !o_b[v].
  - Grant goes to the first eligible VC scanning from RR pointer+1, wrapping modulo N_VC.
  - o_v = |eligible; o_vc = granted VC; o_d = head of FIFO[granted].
  - When o_v==0, o_vc and o_d hold the value for VC 0 (don't-care, but defined, not X-propagating).
  - Downstream has no ready signal: o_v==1 means the flit is consumed at that edge. The granted FIFO pops, and the RR pointer loads the granted VC.
  - The RR pointer holds when no grant is made.
- Latency: a flit pushed at edge t can appear on o_d in cycle t+1 at the earliest. There is no combinational i_d→o_d bypass.
- Simultaneous push and pop on the same VC: count unchanged, both pointers advance. This is legal even when cnt==DEPTH.
- Pointers wrap explicitly from DEPTH-1 to 0. Count width is clog2(DEPTH+1).
- o_b toggling while a VC is non-empty: that VC drops out of arbitration in the same cycle, with no loss and no duplication.
- FIFO order is preserved per VC. There is no ordering guarantee across VCs.
- Reset asserted mid-traffic: all buffered flits are discarded, and outputs reach their reset values immediately.

Decomposition:
- Shared package noc_pkg:
  - vc_w(N) function returning max(1, clog2(N)), used for VC_W.
  - Count-width helper.
  - Common flit typedef, if D_W is fixed project-wide.
- Sub-module vc_fifo (one per VC, generate loop):
  - Parameters D_W, DEPTH, SKID.
  - Ports: push, pop, data in, head data, cnt, registered almost-full (drives i_b[v]), overflow pulse.
  - Top level holds the round-robin arbiter, the output mux and the err flop.

Test Plan:
- Reset then idle, N_VC=2, DEPTH=4, SKID=1 → i_b=2'b00, o_v=0, err=0. Asserting rst low mid-stream clears all counts, and o_v drops in the same cycle.
- Stream 4 flits 0xA0..0xA3 on VC0 with o_b=2'b01 → i_b[0] rises in the cycle after the 3rd push. Release o_b: outputs 0xA0..0xA3 appear in order with o_vc=0, one per cycle.
- VC0 and VC1 each hold 3 flits, o_b=0 → o_vc sequence 0,1,0,1,0,1 (alternating, VC0 first after reset).
- VC1 backpressured, VC0 has data → only VC0 is granted. Drop o_b[1] → the next grant goes to VC1 when the RR pointer is at 0.
- Fill VC0 to 4, then push a 5th flit with no pop → the flit is dropped and err=1 stays high. Repeat with a same-cycle pop instead → the flit is accepted and err stays 0.
- Push i_vc=1 with o_b=0 and an empty FIFO → o_v=1 exactly one cycle after the push edge, never in the same cycle.
